// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// slave: sequencer side (lock/enable/soft-reset in, resets/status out).
// master: environment side (drives lock/enable/soft-reset, observes status).
interface pll_reset_sequencer_if;

    logic       pll_locked;
    logic       core_enable;
    logic       soft_reset_req;
    logic       video_reset;
    logic       core_reset;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic [2:0] seq_state;

    modport master (
        output pll_locked,
        output core_enable,
        output soft_reset_req,
        input  video_reset,
        input  core_reset,
        input  ready,
        input  lock_loss_count,
        input  seq_state
    );

    modport slave (
        input  pll_locked,
        input  core_enable,
        input  soft_reset_req,
        output video_reset,
        output core_reset,
        output ready,
        output lock_loss_count,
        output seq_state
    );

endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies raw PLL lock, then releases video reset and, after a stagger,
// core reset; re-asserts both on lock loss and counts those losses.
// Ports: clk, rst (sync, active-high), bus (pll_reset_sequencer_if.slave):
//   in  pll_locked, core_enable, soft_reset_req
//   out video_reset, core_reset, ready, lock_loss_count[7:0], seq_state[2:0]
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.slave  bus
);

    localparam int MAX_AB =
        (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_ALL =
        (MAX_AB > STAGGER_CYCLES) ? MAX_AB : STAGGER_CYCLES;
    // Guard keeps the counter at least one bit wide for tiny settings.
    localparam int CW = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        HOLD      = 3'd2,
        VIDEO_UP  = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_n;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_n;
    logic [7:0]             loss_q;
    logic [7:0]             loss_n;
    logic                   loss_inc;
    logic                   video_q;
    logic                   core_q;
    logic                   ready_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    // Lock synchronizer: shift in at bit 0, use the oldest bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        loss_inc = 1'b0;

        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // Counter parks at its last value while waiting for enable.
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    if (bus.core_enable) begin
                        state_n = VIDEO_UP;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            VIDEO_UP: begin
                if (!locked_s) begin
                    state_n  = WAIT_LOCK;
                    loss_inc = 1'b1;
                end else if (!bus.core_enable) begin
                    state_n = HOLD;
                end else if (cnt_q == STAGGER_LAST) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_n  = WAIT_LOCK;
                    loss_inc = 1'b1;
                end else if (!bus.core_enable || bus.soft_reset_req) begin
                    state_n = HOLD;
                end
            end
            default: begin
                state_n = WAIT_LOCK;
            end
        endcase

        if (state_n != state_q) begin
            cnt_n = '0;
        end

        loss_n = loss_q;
        if (loss_inc && (loss_q != 8'hFF)) begin
            loss_n = loss_q + 8'd1;
        end
    end

    // Outputs decoded from the next state so they change with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            loss_q  <= 8'd0;
            video_q <= 1'b1;
            core_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            loss_q  <= loss_n;
            video_q <= !((state_n == VIDEO_UP) || (state_n == RUN));
            core_q  <= (state_n != RUN);
            ready_q <= (state_n == RUN);
        end
    end

    assign bus.video_reset     = video_q;
    assign bus.core_reset      = core_q;
    assign bus.ready           = ready_q;
    assign bus.lock_loss_count = loss_q;
    assign bus.seq_state       = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the core PLL, in the 32 MHz core clock domain.
- Takes the PLL's raw, asynchronous lock indication and qualifies it for stability.
- Releases video reset first, then CPU/core reset after a stagger, and only once the bridge reports the ROM is loaded.
- Re-asserts both resets on loss of lock and counts lock-loss events for the status register.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for pll_locked; minimum 2.
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before the hold phase.
- HOLD_CYCLES, 64: cycles both resets are held after lock is qualified.
- STAGGER_CYCLES, 16: cycles between video_reset release and core_reset release.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL lock, asynchronous to clk.
- core_enable  in  1  level from bridge, high when ROM is loaded and the core may run.
- soft_reset_req  in  1  single-cycle pulse requesting a core restart.
- video_reset  out  1  active-high reset for the video/LCD path.
- core_reset  out  1  active-high reset for the CPU and peripherals.
- ready  out  1  high only in RUN.
- lock_loss_count  out  8  saturating count of lock losses from VIDEO_UP or RUN.
- seq_state  out  3  state encoding: WAIT_LOCK=0, STABLE=1, HOLD=2, VIDEO_UP=3, RUN=4.

Behaviour:
- Synchronizer:
  - pll_locked passes through SYNC_STAGES flops; the last stage is locked_s.
  - All stages clear to 0 on rst.
- Counter:
  - Single shared counter, width $clog2(max(STABLE_CYCLES, HOLD_CYCLES, STAGGER_CYCLES)).
  - Cleared on every state transition.
- Reset values (rst high): state WAIT_LOCK, counter 0, video_reset 1, core_reset 1, ready 0, lock_loss_count 0, seq_state 0.
- Outputs are registered and update on the same edge as the state register:
  - video_reset = 0 only in VIDEO_UP and RUN.
  - core_reset = 0 only in RUN.
  - ready = 1 only in RUN.
- WAIT_LOCK: locked_s=1 -> STABLE.
- STABLE:
  - locked_s=0 -> WAIT_LOCK; lock_loss_count unchanged.
  - Else if counter == STABLE_CYCLES-1 -> HOLD.
  - Else counter+1.
- HOLD:
  - locked_s=0 -> WAIT_LOCK; lock_loss_count unchanged.
  - Counter increments to HOLD_CYCLES-1 and holds there.
  - Exit to VIDEO_UP on the first edge where counter == HOLD_CYCLES-1 and core_enable=1. With core_enable low, stay in HOLD indefinitely.
- VIDEO_UP:
  - locked_s=0 -> WAIT_LOCK and lock_loss_count+1.
  - core_enable=0 -> HOLD.
  - Else if counter == STAGGER_CYCLES-1 -> RUN.
  - Else counter+1.
- RUN:
  - locked_s=0 -> WAIT_LOCK and lock_loss_count+1.
  - Else core_enable=0 or soft_reset_req=1 -> HOLD (counter 0, no count).
- Priority: rst > lock loss > core_enable drop / soft_reset_req > counter progress.
- soft_reset_req is ignored outside RUN.
- lock_loss_count saturates at 255.
- Latency from first clk edge sampling pll_locked=1 at the first sync stage (t0), with core_enable already high and lock steady:
  - Video release: video_reset falls at edge t0+SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES.
  - Core release: core_reset falls STAGGER_CYCLES edges later.
- Lock loss response: both resets assert on the edge after locked_s goes low. Latency from a pll_locked fall is SYNC_STAGES+1 edges.
- rst asserted mid-sequence: immediate return to reset values, including lock_loss_count.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, STAGGER_CYCLES=2):
- rst for 3 cycles, core_enable=1, pll_locked rises at t0 and stays high -> video_reset falls at edge t0+14, core_reset and ready at t0+16, seq_state 0->1->2->3->4.
- pll_locked high for only 5 cycles, then low, then high permanently -> sequence returns to WAIT_LOCK, lock_loss_count stays 0, full 14/16-edge release measured from the second rise.
- core_enable=0 with lock steady -> seq_state parks at 2, both resets stay 1. core_enable rises at edge T -> video_reset falls at T+1, core_reset at T+3.
- In RUN, pulse soft_reset_req -> core_reset and video_reset high next edge, seq_state=2. Rerelease: video_reset falls 4 edges later, core_reset 2 edges after that. lock_loss_count unchanged.
- In RUN, drop pll_locked at edge L -> resets assert at L+3, lock_loss_count=1. Repeat 300 times -> count saturates at 255.
- Same-cycle soft_reset_req and locked_s fall in RUN -> state WAIT_LOCK, lock_loss_count+1. Assert rst in VIDEO_UP -> all outputs at reset values next edge.
